// File: rtl/mux2to1_arbiter.sv
// Round-robin arbiter driving a shared 2:1 mux; grant/sel one cycle after request, data two cycles.
// Optional burst limit under MUX2TO1_ARB_BURST_LIMIT_EN bounds how long a held request keeps the mux under contention.
module mux2to1_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req0,
   input  logic             i_req1,
   input  logic [WIDTH-1:0] i_in0,
   input  logic [WIDTH-1:0] i_in1,
   output logic             o_gnt0,
   output logic             o_gnt1,
   output logic             o_sel,
   output logic [WIDTH-1:0] o_out,
   output logic             o_out_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_last;
   logic               r_gnt0;
   logic               r_gnt1;
   logic               r_sel;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out;
   logic               w_limit0;
   logic               w_limit1;

   if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
      $error("MAX_BURST must be in 1..255");
   end

`ifdef MUX2TO1_ARB_BURST_LIMIT_EN
   localparam int unsigned     CW      = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_BURST);

   logic [CW-1:0] r_cnt;

   // A saturated count only forces a handover when the other side is waiting.
   assign w_limit0 = (r_cnt == MAX_CNT) && i_req1;
   assign w_limit1 = (r_cnt == MAX_CNT) && i_req0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (w_next != IDLE && w_next != r_state) begin
         r_cnt <= CW'(1);
      end else if (w_next != IDLE && r_cnt != MAX_CNT) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end
`else
   assign w_limit0 = 1'b0;
   assign w_limit1 = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_req0 && (!i_req1 || r_last)) begin
               w_next = G0;
            end else if (i_req1) begin
               w_next = G1;
            end
         end
         G0: begin
            if (!i_req0 || w_limit0) begin
               w_next = i_req1 ? G1 : IDLE;
            end
         end
         G1: begin
            if (!i_req1 || w_limit1) begin
               w_next = i_req0 ? G0 : IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_sel       <= 1'b0;
         r_last      <= 1'b1;
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         r_gnt0  <= (w_next == G0);
         r_gnt1  <= (w_next == G1);
         if (w_next == G0 && r_state != G0) begin
            r_sel  <= 1'b0;
            r_last <= 1'b0;
         end else if (w_next == G1 && r_state != G1) begin
            r_sel  <= 1'b1;
            r_last <= 1'b1;
         end
         // Capture uses the pre-edge sel, so out follows sel by one cycle.
         if (r_state != IDLE) begin
            r_out       <= r_sel ? i_in1 : i_in0;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_gnt0      = r_gnt0;
   assign o_gnt1      = r_gnt1;
   assign o_sel       = r_sel;
   assign o_out       = r_out;
   assign o_out_valid = r_out_valid;

endmodule

// File: doc/mux2to1_arbiter.md
# mux2to1_arbiter

Two-requester round-robin arbiter that shares one 2:1 mux datapath between requester 0 (`in0`) and requester 1 (`in1`). It sequences the mux `sel` from a registered grant state machine and registers the selected data with a valid flag. An optional burst limit bounds how long one requester can hold the mux while the other waits. The block sits directly in front of the shared mux resource and replaces ad hoc `sel` driving.

## Interface
- `WIDTH`, 8: data width of `in0`, `in1` and `out`.
- `MAX_BURST`, 4: maximum consecutive grant cycles under contention. Range 1..255; used only with the macro.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0` in 1: requester 0 request, level; held while it wants the mux.
- `req1` in 1: requester 1 request, level.
- `in0` in WIDTH: requester 0 data.
- `in1` in WIDTH: requester 1 data.
- `gnt0` out 1: requester 0 owns the mux; registered.
- `gnt1` out 1: requester 1 owns the mux; registered.
- `sel` out 1: mux select, 1 = `in1`; registered.
- `out` out WIDTH: registered mux output.
- `out_valid` out 1: `out` holds data captured during a grant cycle.

## Operation
- States: IDLE, G0, G1.
  - `gnt0` = (state==G0).
  - `gnt1` = (state==G1).
  - `gnt0` and `gnt1` are never both 1.
- `last` flag records the most recently granted requester. Reset value is 1, so requester 0 wins the first tie.
- IDLE:
  - req0&req1 → G0 if `last`==1, else G1.
  - req0 only → G0.
  - req1 only → G1.
  - neither → stay in IDLE.
- G0 (G1 symmetric):
  - req0==0 and req1==1 → G1 directly, no idle gap.
  - req0==0 and req1==0 → IDLE.
  - req0==1 → stay in G0, except when the burst limit applies (see Configuration).
- `last` updates on every entry into G0 (to 0) or G1 (to 1).
- `sel`:
  - Set to 1 on entry to G1, to 0 on entry to G0.
  - Holds its value in IDLE.
- Datapath, evaluated every rising edge:
  - If state is G0 or G1: `out` ← (`sel` ? `in1` : `in0`) and `out_valid` ← 1.
  - Else: `out` holds and `out_valid` ← 0.
- Reset values: state IDLE, `gnt0`=0, `gnt1`=0, `sel`=0, `out`=0, `out_valid`=0, `last`=1, burst count 0.
- Reset asserted mid-grant drops the grant asynchronously. After release, arbitration restarts from IDLE with requester 0 priority.

## Timing
- Request sampled at edge k → grant and `sel` valid after edge k+1.
- First `out_valid` after edge k+2. Total latency: 2 cycles from request to data.
- Requester data must be stable during each cycle its grant is high. One data word is captured per grant cycle.
- Dropping a request at edge k → grant falls after edge k+1, and `out_valid` falls after edge k+2. One extra word is captured; the requester must discard it.
- Handover G0→G1 within one edge: `out_valid` stays high continuously. `out` switches source one cycle after `sel`.
- A request changing in the same cycle as the grant edge follows the sampled value only; there is no combinational path from any request to any output.

## Configuration
- Macro: `MUX2TO1_ARB_BURST_LIMIT_EN`.
- Defined:
  - Burst counter of width ceil(log2(MAX_BURST+1)) is set to 1 on grant entry and increments per held cycle, saturating at `MAX_BURST`.
  - In G0, counter==`MAX_BURST` and req1==1 → G1, even if req0 is still 1 (G1 symmetric).
  - Without a competing request, the grant is held indefinitely with the counter saturated.
- Undefined:
  - No counter is built.
  - A grant is held as long as its request stays high; the other requester can starve.

## Test plan
- Reset: assert `rst`=1 asynchronously during G1 → `gnt1`, `sel`, `out_valid`, `out` go to 0 immediately; after release with req0=req1=1 → G0 granted first.
- Single requester: req0=1 for 3 cycles with `in0`=0x5A → `gnt0` high for 3 cycles starting 1 cycle later; `out`=0x5A with `out_valid` high for 3 cycles starting 2 cycles after request.
- Tie alternation: pulse req0=req1=1 for 1 cycle, idle, then repeat → grants alternate G0, G1, G0.
- Direct handover: req0 held, req1=1, then req0 drops → `gnt0`→`gnt1` at one edge; `out_valid` stays high; `out` changes from `in0`=0x11 to `in1`=0x22.
- Burst limit (macro on, MAX_BURST=4): req0 and req1 both held → alternating 4-cycle grants. Macro off: `gnt0` stays high for 20+ cycles.
- Idle: req0=req1=0 → `out_valid`=0; `out` and `sel` hold their last values.
